// File: rtl/gtp_pll_seq_pkg.sv
// rtl/gtp_pll_seq_pkg.sv - shared types and helpers for the GTP PLL sequencer
package gtp_pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_HOLD,
    ST_WAIT,
    ST_STABLE,
    ST_LOCKED,
    ST_FAIL
  } seq_state_e;

  // Width of the per-PLL retry count reported at the top level (saturating).
  localparam int RETRY_W = 2;

  // Bits needed to hold the largest of the three timing limits without wrapping.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gtp_pll_chan_seq.sv
// rtl/gtp_pll_chan_seq.sv - one PLL's lock synchroniser, power/reset/lock FSM and timers (GTP_PLL_SEQ_RELOCK_EN selects relock on lock loss)
module gtp_pll_chan_seq
  import gtp_pll_seq_pkg::*;
#(
  parameter bit USED         = 1'b1,
  parameter int RESET_CYCLES = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 32,
  parameter int MAX_RETRIES  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               pll_lock,
  output logic               pll_pd,
  output logic               pll_reset,
  output logic               locked,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int TW = timer_width(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  // Internal retry count holds one more than MAX_RETRIES so the final timeout is visible.
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam logic [TW-1:0] RESET_LAST   = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_CNT   = TW'(LOCK_STABLE);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  seq_state_e         state_q, state_d;
  logic [1:0]         sync_q, sync_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [TW-1:0]      stab_q, stab_d;
  logic [RW-1:0]      retries_q, retries_d;
  logic               pd_q, pd_d;
  logic               rst_q, rst_d;
  logic               locked_q, locked_d;
  logic               fail_q, fail_d;
  logic [RETRY_W-1:0] retry_out_q, retry_out_d;
  logic               lock_s;
  logic               timeout;
  logic [RW-1:0]      retry_inc;

  assign lock_s = sync_q[1];

  // Next-state, timer and output decode; outputs follow the next state so they register with it
  always_comb begin
    sync_d    = {sync_q[0], pll_lock};
    state_d   = state_q;
    timer_d   = timer_q;
    stab_d    = stab_q;
    retries_d = retries_q;
    timeout   = (timer_q == TIMEOUT_LAST);
    retry_inc = retries_q + RW'(1);
    if (!enable) begin
      state_d   = ST_OFF;
      timer_d   = '0;
      stab_d    = '0;
      retries_d = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (USED) begin
            state_d   = ST_HOLD;
            timer_d   = '0;
            retries_d = '0;
          end
        end
        ST_HOLD: begin
          if (timer_q == RESET_LAST) begin
            state_d = ST_WAIT;
            timer_d = '0;
            stab_d  = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_WAIT, ST_STABLE: begin
          if (timeout) begin
            retries_d = retry_inc;
            timer_d   = '0;
            stab_d    = '0;
            state_d   = (retry_inc > RETRY_MAX) ? ST_FAIL : ST_HOLD;
          end else begin
            timer_d = timer_q + TW'(1);
            if (state_q == ST_WAIT) begin
              if (lock_s) begin
                state_d = ST_STABLE;
                stab_d  = TW'(1);
              end
            end else if (!lock_s) begin
              state_d = ST_WAIT;
              stab_d  = '0;
            end else if (stab_q == STABLE_CNT) begin
              state_d = ST_LOCKED;
            end else begin
              stab_d = stab_q + TW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (!lock_s) begin
`ifdef GTP_PLL_SEQ_RELOCK_EN
            state_d   = ST_HOLD;
            timer_d   = '0;
            stab_d    = '0;
            retries_d = '0;
`else
            state_d   = ST_FAIL;
`endif
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_OFF;
      endcase
    end
    pd_d        = (state_d == ST_OFF) || (state_d == ST_FAIL);
    rst_d       = (state_d == ST_OFF) || (state_d == ST_HOLD) || (state_d == ST_FAIL);
    locked_d    = (state_d == ST_LOCKED);
    fail_d      = (state_d == ST_FAIL);
    retry_out_d = (int'(retries_d) >= 3) ? '1 : RETRY_W'(retries_d);
  end

  // Synchroniser, FSM state, timers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= ST_OFF;
      timer_q     <= '0;
      stab_q      <= '0;
      retries_q   <= '0;
      pd_q        <= 1'b1;
      rst_q       <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      retry_out_q <= '0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      stab_q      <= stab_d;
      retries_q   <= retries_d;
      pd_q        <= pd_d;
      rst_q       <= rst_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      retry_out_q <= retry_out_d;
    end
  end

  assign pll_pd    = pd_q;
  assign pll_reset = rst_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_out_q;

endmodule

// File: rtl/gtp_pll_sequencer.sv
// rtl/gtp_pll_sequencer.sv - GTPE2_COMMON PLL power-up/reset/lock sequencer top (GTP_PLL_SEQ_RELOCK_EN selects relock on lock loss)
module gtp_pll_sequencer
  import gtp_pll_seq_pkg::*;
#(
  parameter int         NUM_PLL      = 2,
  parameter logic [1:0] PLL_USED     = 2'b01,
  parameter int         RESET_CYCLES = 64,
  parameter int         LOCK_TIMEOUT = 4096,
  parameter int         LOCK_STABLE  = 32,
  parameter int         MAX_RETRIES  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_PLL-1:0]           pll_lock,
  output logic [NUM_PLL-1:0]           pll_pd,
  output logic [NUM_PLL-1:0]           pll_reset,
  output logic [NUM_PLL-1:0]           locked,
  output logic [NUM_PLL-1:0]           fail,
  output logic                         all_locked,
  output logic                         any_fail,
  output logic [NUM_PLL*RETRY_W-1:0]   retry_cnt
);

  localparam logic [NUM_PLL-1:0] USED_MASK = PLL_USED[NUM_PLL-1:0];

  logic all_locked_q, all_locked_d;
  logic any_fail_q, any_fail_d;

  for (genvar i = 0; i < NUM_PLL; i++) begin : g_chan
    gtp_pll_chan_seq #(
      .USED         (USED_MASK[i]),
      .RESET_CYCLES (RESET_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .LOCK_STABLE  (LOCK_STABLE),
      .MAX_RETRIES  (MAX_RETRIES)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .pll_lock  (pll_lock[i]),
      .pll_pd    (pll_pd[i]),
      .pll_reset (pll_reset[i]),
      .locked    (locked[i]),
      .fail      (fail[i]),
      .retry_cnt (retry_cnt[i*RETRY_W +: RETRY_W])
    );
  end

  // Aggregate status over used PLLs; a build with no used PLL never reports locked
  always_comb begin
    all_locked_d = (USED_MASK != '0) && (&(locked | ~USED_MASK));
    any_fail_d   = |(fail & USED_MASK);
  end

  // Register the aggregate status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_locked_q <= 1'b0;
      any_fail_q   <= 1'b0;
    end else begin
      all_locked_q <= all_locked_d;
      any_fail_q   <= any_fail_d;
    end
  end

  assign all_locked = all_locked_q;
  assign any_fail   = any_fail_q;

endmodule
